// File: rtl/sdram_ring_if.sv
// Bus bundle for sdram_ring: sample stream in/out, SDRAM request/response, flush and status.
// The slave modport is the ring itself; master is whatever drives it (controller plus stream ends).
// Optional macro SDRAM_RING_DROP_EN adds the sticky overflow flag.
interface sdram_ring_if;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_ready;
  logic        avalid;
  logic        aready;
  logic        awe;
  logic [23:0] aaddr;
  logic [15:0] adata;
  logic        bvalid;
  logic        bwe;
  logic [15:0] bdata;
  logic        clear;
  logic [24:0] level;
  logic        full;
`ifdef SDRAM_RING_DROP_EN
  logic        overflow;
`endif

  modport slave (
`ifdef SDRAM_RING_DROP_EN
    output overflow,
`endif
    input  s_valid, s_data, o_ready, aready, bvalid, bwe, bdata, clear,
    output s_ready, o_valid, o_data, avalid, awe, aaddr, adata, level, full
  );

  modport master (
`ifdef SDRAM_RING_DROP_EN
    input  overflow,
`endif
    output s_valid, s_data, o_ready, aready, bvalid, bwe, bdata, clear,
    input  s_ready, o_valid, o_data, avalid, awe, aaddr, adata, level, full
  );
endinterface

// File: rtl/sdram_ring.sv
// SDRAM-backed sample FIFO. Writes go to wr_ptr, reads are fetched from rd_ptr into a small
// output buffer whose space is reserved by a read-credit count. Writes win arbitration.
// Optional macro SDRAM_RING_DROP_EN: never backpressure, drop samples that cannot be taken
// and raise a sticky overflow flag.
module sdram_ring #(
  parameter int unsigned OBUF_DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  sdram_ring_if.slave bus
);
  localparam int unsigned CntW = $clog2(OBUF_DEPTH + 1);
  localparam int unsigned IdxW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam logic [24:0] LevelFull = 25'h1000000;

  logic            req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [23:0]     req_addr_q, req_addr_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]     req_data_q, req_data_d;
  logic [24:0]     level_q, level_d;
  logic [CntW-1:0] rd_out_q, rd_out_d, disc_q, disc_d, ob_cnt_q, ob_cnt_d;
  logic [CntW-1:0] rd_out_after, disc_after;
  logic [CntW+1:0] credit_used;
  logic [IdxW-1:0] ob_head_q, ob_head_d, ob_tail_q, ob_tail_d;
  logic [15:0]     ob_mem [OBUF_DEPTH];
  logic            full, loadable, wr_ok, wr_want, wr_load, rd_load;
  logic            resp_rd, disc_nz, drop_rd, ob_push, ob_pop;

  assign full     = (level_q == LevelFull);
  assign loadable = !req_valid_q || bus.aready;
  assign wr_ok    = loadable && !full && !bus.clear;
  assign wr_load  = bus.s_valid && wr_ok;
  // A full ring with a waiting sample must still drain, so only a takeable write blocks reads.
  assign wr_want  = bus.s_valid && !full;
  // Discarded responses still occupy the controller, so they consume credit too.
  assign credit_used = (CntW+2)'(rd_out_q) + (CntW+2)'(disc_q) + (CntW+2)'(ob_cnt_q);
  assign rd_load  = !wr_want && (level_q != '0) && (credit_used < (CntW+2)'(OBUF_DEPTH))
                    && loadable && !bus.clear;
  assign resp_rd  = bus.bvalid && !bus.bwe;
  assign disc_nz  = (disc_q != '0);
  assign drop_rd  = req_valid_q && !bus.aready && !req_we_q;
  assign ob_push  = resp_rd && !disc_nz && !bus.clear;
  assign ob_pop   = (ob_cnt_q != '0) && bus.o_ready && !bus.clear;

`ifdef SDRAM_RING_DROP_EN
  logic overflow_q, overflow_d;
  assign bus.s_ready  = !rst;
  assign bus.overflow = overflow_q;

  // Sticky overflow on the first sample that could not be taken.
  always_comb begin
    overflow_d = overflow_q | (bus.s_valid && !wr_ok && !bus.clear && !rst);
    if (bus.clear) overflow_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end
`else
  assign bus.s_ready = !rst && wr_ok;
`endif

  assign bus.avalid  = req_valid_q;
  assign bus.awe     = req_we_q;
  assign bus.aaddr   = req_addr_q;
  assign bus.adata   = req_data_q;
  assign bus.level   = level_q;
  assign bus.full    = full;
  assign bus.o_valid = (ob_cnt_q != '0);
  assign bus.o_data  = (ob_cnt_q != '0) ? ob_mem[ob_head_q] : '0;

  // Next state for request register, pointers, level, credit/discard and obuf indices.
  always_comb begin
    req_valid_d  = req_valid_q && !bus.aready;
    req_we_d     = req_we_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    wr_ptr_d     = wr_ptr_q + 24'(wr_load);
    rd_ptr_d     = rd_ptr_q + 24'(rd_load);
    level_d      = level_q + 25'(wr_load) - 25'(rd_load);
    rd_out_after = rd_out_q + CntW'(rd_load) - CntW'(resp_rd && !disc_nz);
    disc_after   = disc_q - CntW'(resp_rd && disc_nz);
    rd_out_d     = rd_out_after;
    disc_d       = disc_after;
    ob_head_d    = ob_head_q;
    ob_tail_d    = ob_tail_q;
    ob_cnt_d     = ob_cnt_q + CntW'(ob_push) - CntW'(ob_pop);
    if (ob_push) ob_tail_d = (ob_tail_q == IdxW'(OBUF_DEPTH - 1)) ? '0 : ob_tail_q + IdxW'(1);
    if (ob_pop)  ob_head_d = (ob_head_q == IdxW'(OBUF_DEPTH - 1)) ? '0 : ob_head_q + IdxW'(1);
    if (wr_load) begin
      req_valid_d = 1'b1;
      req_we_d    = 1'b1;
      req_addr_d  = wr_ptr_q;
      req_data_d  = bus.s_data;
    end else if (rd_load) begin
      req_valid_d = 1'b1;
      req_we_d    = 1'b0;
      req_addr_d  = rd_ptr_q;
    end
    if (bus.clear) begin
      // A read still parked in the register never reaches the controller, so it owes nothing.
      req_valid_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      disc_d      = disc_after + rd_out_after - CntW'(drop_rd);
      rd_out_d    = '0;
      ob_head_d   = '0;
      ob_tail_d   = '0;
      ob_cnt_d    = '0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_out_q    <= '0;
      disc_q      <= '0;
      ob_head_q   <= '0;
      ob_tail_q   <= '0;
      ob_cnt_q    <= '0;
    end else begin
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_out_q    <= rd_out_d;
      disc_q      <= disc_d;
      ob_head_q   <= ob_head_d;
      ob_tail_q   <= ob_tail_d;
      ob_cnt_q    <= ob_cnt_d;
    end
  end

  // Output buffer storage; contents are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (ob_push) ob_mem[ob_tail_q] <= bus.bdata;
  end

  // Arbitration makes simultaneous write and read loads impossible.
  a_no_dual_load: assert property (@(posedge clk) disable iff (rst) !(wr_load && rd_load));
  // Credit accounting keeps the output buffer from overflowing.
  a_obuf_no_ovf: assert property (@(posedge clk) disable iff (rst)
    !(ob_push && !ob_pop && ob_cnt_q == CntW'(OBUF_DEPTH)));
endmodule
